hilo_seq: RTL
=============

# hilo_seq

Iterative multiply/divide sequencer that owns the architectural HI/LO registers of the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from the EX stage and runs multiply and divide as a fixed-latency radix-2 loop, one bit per clock. It drives `busy` so the pipeline stalls on a new HI/LO request or an MFHI/MFLO read. It supports a flush, which cancels an in-flight operation on an exception.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only when `ready`=1
- funct  in  6  operation; `funct_mult`, `funct_multu`, `funct_div`, `funct_divu`, `funct_mthi`, `funct_mtlo` from def.v (0x18, 0x19, 0x1A, 0x1B, 0x11, 0x13)
- a  in  WIDTH  rs operand (dividend/multiplicand; source for MTHI/MTLO)
- b  in  WIDTH  rt operand (divisor/multiplier)
- flush  in  1  cancel in-flight operation
- ready  out  1  block idle, can accept a request (= !busy)
- busy  out  1  MUL/DIV in progress; pipeline stalls MFHI/MFLO and new requests
- done  out  1  one-cycle pulse: hi/lo just updated by MUL/DIV
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start + MUL/DIV funct:
  - latch |a|, |b| (magnitudes only for signed ops, else raw), sign flags, and op type
  - clear the 2·WIDTH accumulator and the iteration counter
  - go to CALC
- IDLE + start + MTHI/MTLO: write `a` into hi or lo at that edge; stay IDLE; no busy, no done.
- IDLE + start + any other funct: ignored.
- CALC, one iteration per clock, counter 0..WIDTH-1:
  - multiply: shift-add, multiplier LSB-first; accumulator holds the 2·WIDTH unsigned product
  - divide: restoring; shift remainder left with the next dividend bit; subtract |b| if remainder ≥ |b|; quotient bit = 1 on subtract
  - after iteration WIDTH-1 go to FIX
- FIX, one cycle:
  - MULT: negate the 2·WIDTH product if sign(a)≠sign(b)
  - DIV: negate the quotient if sign(a)≠sign(b); the remainder takes the sign of a
  - then {hi,lo}=product (MUL) or hi=remainder, lo=quotient (DIV)
  - done=1 next cycle; go to IDLE
- Divide by zero, no trap:
  - DIVU: lo=0xFFFFFFFF, hi=a
  - DIV: hi=a; lo=0xFFFFFFFF if a≥0, lo=0x00000001 if a<0
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored, including MTHI/MTLO. The requester holds the request until ready.
- flush:
  - in CALC/FIX: return to IDLE next edge; hi/lo unchanged; no done
  - in IDLE: a same-cycle start is dropped, because flush has priority
- hi/lo change only on an MTHI/MTLO edge or the FIX edge. Operands a/b may change after the start edge.

## Timing
- Reset (async, rst_n=0): state IDLE, hi=0, lo=0, busy=0, ready=1, done=0, counter=0.
- Reset mid-operation aborts immediately; no done.
- MUL/DIV accepted at edge E0:
  - busy=1 from E0 through E(WIDTH+1)
  - hi/lo valid and done=1 in the cycle after edge E(WIDTH+1)
  - latency WIDTH+1 clocks (33 at WIDTH=32)
- Back-to-back: a new start is accepted in the done cycle. The next result arrives exactly WIDTH+1 clocks later.
- MTHI/MTLO: value visible in hi/lo the cycle after the accepting edge.
- done is a single-cycle pulse, never asserted together with busy.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF → after 33 clocks hi=0xFFFFFFFE, lo=0x00000001, done pulse 1 cycle, busy high exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3) b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Back-to-back DIV a=-7 b=2 issued in the done cycle → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 → lo=0xFFFFFFFF, hi=100. DIV a=0xFFFFFFF6 b=0 → lo=1, hi=0xFFFFFFF6. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → hi/lo updated 1 cycle after each; busy never 1; done never 1.
- Start DIVU, assert flush at cycle 10 → IDLE next cycle, hi/lo keep prior values, no done. A start+MTHI held during busy has no effect until ready.
- Assert rst_n=0 mid-CALC → hi=lo=0, busy=0 immediately. Random signed/unsigned MUL/DIV regression vs. a 64-bit reference model.

Source files
------------

// File: rtl/hilo_seq.sv
// HI/LO owner for the MIPS core: iterative radix-2 multiply/divide (one bit per clock)
// plus MTHI/MTLO writes, with a busy/ready handshake and flush-based cancellation.
module hilo_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     opA_q, opB_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 isDiv_q, negRes_q, negRem_q;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 busy_q, done_q;

    logic                 isSigned;
    logic [WIDTH-1:0]     absA, absB;
    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   mulNext;
    logic [WIDTH:0]       remShift;
    logic                 remGe;
    logic [WIDTH-1:0]     remSub;
    logic [2*WIDTH-1:0]   divNext;
    logic [2*WIDTH-1:0]   prodFix;
    logic [WIDTH-1:0]     quoFix, remFix;

    // Divide keeps {remainder, quotient} in acc; multiply keeps the partial product and
    // shifts right. The remainder-minus-divisor result always fits WIDTH bits when taken.
    always_comb begin
        isSigned = (funct_i == FUNCT_MULT) || (funct_i == FUNCT_DIV);
        absA     = (isSigned && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
        absB     = (isSigned && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;

        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opB_q[0] ? {1'b0, opA_q} : '0);
        mulNext  = {mulSum, acc_q[WIDTH-1:1]};

        remShift = {acc_q[2*WIDTH-1:WIDTH], opA_q[WIDTH-1]};
        remGe    = remShift >= {1'b0, opB_q};
        remSub   = remShift[WIDTH-1:0] - opB_q;
        divNext  = {(remGe ? remSub : remShift[WIDTH-1:0]), acc_q[WIDTH-2:0], remGe};

        prodFix  = negRes_q ? ('0 - acc_q) : acc_q;
        quoFix   = negRes_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        remFix   = negRem_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            isDiv_q  <= 1'b0;
            negRes_q <= 1'b0;
            negRem_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Flush wins over a same-cycle request, including MTHI/MTLO.
                    if (start_i && !flush_i) begin
                        case (funct_i)
                            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
                                opA_q    <= absA;
                                opB_q    <= absB;
                                acc_q    <= '0;
                                cnt_q    <= '0;
                                isDiv_q  <= funct_i[1];
                                negRes_q <= isSigned && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                                negRem_q <= isSigned && a_i[WIDTH-1];
                                busy_q   <= 1'b1;
                                state_q  <= CALC;
                            end
                            FUNCT_MTHI: hi_q <= a_i;
                            FUNCT_MTLO: lo_q <= a_i;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        if (isDiv_q) begin
                            acc_q <= divNext;
                            opA_q <= {opA_q[WIDTH-2:0], 1'b0};
                        end else begin
                            acc_q <= mulNext;
                            opB_q <= {1'b0, opB_q[WIDTH-1:1]};
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (!flush_i) begin
                        if (isDiv_q) begin
                            hi_q <= remFix;
                            lo_q <= quoFix;
                        end else begin
                            {hi_q, lo_q} <= prodFix;
                        end
                        done_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign ready_o = !busy_q;
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule
